// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch port, the load/store port, the memory and mem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding core/memory side.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32
) ();

    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_addr;
    logic              if_resp_valid;
    logic [31:0]       if_rdata;

    logic              d_req_valid;
    logic              d_req_ready;
    logic [ADDR_W-1:0] d_addr;
    logic              d_we;
    logic [31:0]       d_wdata;
    logic [3:0]        d_wstrb;
    logic              d_resp_valid;
    logic [31:0]       d_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_r_enable;
    logic              mem_w_enable;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_rdata;

    modport slave (
        input  if_req_valid, if_addr,
        input  d_req_valid, d_addr, d_we, d_wdata, d_wstrb,
        input  mem_rdata,
        output if_req_ready, if_resp_valid, if_rdata,
        output d_req_ready, d_resp_valid, d_rdata,
        output mem_addr, mem_r_enable, mem_w_enable, mem_wdata, mem_wstrb
    );

    modport master (
        output if_req_valid, if_addr,
        output d_req_valid, d_addr, d_we, d_wdata, d_wstrb,
        output mem_rdata,
        input  if_req_ready, if_resp_valid, if_rdata,
        input  d_req_ready, d_resp_valid, d_rdata,
        input  mem_addr, mem_r_enable, mem_w_enable, mem_wdata, mem_wstrb
    );

endinterface

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter in front of one single-port synchronous memory, 1-cycle response.
// MEM_ARB_RR_EN selects round-robin arbitration instead of data priority with a fetch starvation limit.
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 32
`ifndef MEM_ARB_RR_EN
   ,parameter int unsigned STARVE_LIMIT = 4
`endif
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    state_t state_q, state_d;
    owner_t owner_q, owner_d;
    logic   store_q, store_d;

    logic   if_grant_c;
    logic   d_grant_c;
    logic   fetch_wins_c;
    logic   pending_c;

`ifdef MEM_ARB_RR_EN
    // Set when data took the most recent grant; reset value hands fetch the first contended win.
    logic   last_d_q, last_d_d;

    assign fetch_wins_c = last_d_q;

    always_comb begin
        last_d_d = last_d_q;
        if (d_grant_c) begin
            last_d_d = 1'b1;
        end else if (if_grant_c) begin
            last_d_d = 1'b0;
        end
    end
`else
    logic [3:0] starve_q, starve_d;

    assign fetch_wins_c = (starve_q == 4'(STARVE_LIMIT));

    // Counts consecutive lost cycles of a waiting fetch; saturates so it can never wrap.
    always_comb begin
        starve_d = starve_q;
        if (!bus.if_req_valid || if_grant_c) begin
            starve_d = 4'd0;
        end else if (starve_q != 4'hF) begin
            starve_d = starve_q + 4'd1;
        end
    end
`endif

    // Winner selection; nobody is granted while reset is held.
    always_comb begin
        if_grant_c = 1'b0;
        d_grant_c  = 1'b0;
        if (!rst) begin
            if (bus.if_req_valid && bus.d_req_valid) begin
                if_grant_c = fetch_wins_c;
                d_grant_c  = !fetch_wins_c;
            end else begin
                if_grant_c = bus.if_req_valid;
                d_grant_c  = bus.d_req_valid;
            end
        end
    end

    assign bus.if_req_ready = if_grant_c;
    assign bus.d_req_ready  = d_grant_c;

    // Memory controls follow the winner in the accept cycle and idle at zero otherwise.
    always_comb begin
        bus.mem_addr     = '0;
        bus.mem_r_enable = 1'b0;
        bus.mem_w_enable = 1'b0;
        bus.mem_wdata    = '0;
        bus.mem_wstrb    = '0;
        if (d_grant_c) begin
            bus.mem_addr = bus.d_addr & WORD_MASK;
            if (bus.d_we) begin
                bus.mem_w_enable = 1'b1;
                bus.mem_wdata    = bus.d_wdata;
                bus.mem_wstrb    = bus.d_wstrb;
            end else begin
                bus.mem_r_enable = 1'b1;
            end
        end else if (if_grant_c) begin
            bus.mem_addr     = bus.if_addr & WORD_MASK;
            bus.mem_r_enable = 1'b1;
        end
    end

    // Every accept leaves one response pending for the next cycle, tagged with its owner.
    always_comb begin
        state_d = ST_IDLE;
        owner_d = owner_q;
        store_d = 1'b0;
        if (d_grant_c) begin
            state_d = ST_BUSY;
            owner_d = OWN_D;
            store_d = bus.d_we;
        end else if (if_grant_c) begin
            state_d = ST_BUSY;
            owner_d = OWN_IF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_IF;
            store_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_d_q <= 1'b1;
`else
            starve_q <= 4'd0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            store_q  <= store_d;
`ifdef MEM_ARB_RR_EN
            last_d_q <= last_d_d;
`else
            starve_q <= starve_d;
`endif
        end
    end

    assign pending_c = (state_q == ST_BUSY) && !rst;

    // Response steering: read data passes straight from the memory, store acks carry zero.
    always_comb begin
        bus.if_resp_valid = 1'b0;
        bus.if_rdata      = '0;
        bus.d_resp_valid  = 1'b0;
        bus.d_rdata       = '0;
        if (pending_c) begin
            if (owner_q == OWN_D) begin
                bus.d_resp_valid = 1'b1;
                if (!store_q) begin
                    bus.d_rdata = bus.mem_rdata;
                end
            end else begin
                bus.if_resp_valid = 1'b1;
                bus.if_rdata      = bus.mem_rdata;
            end
        end
    end

endmodule
